// File: rtl/rdback_sender_pkg.sv
// Shared types and sizing helpers for the readback-to-host sender.
// FSM encoding, beat/length arithmetic and the RIFFA word size live here.
package rdback_sender_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_STREAM = 2'd2
    } state_t;

    localparam int RIFFA_WORD_W = 32;

    function automatic int calc_beats(input int fifo_w, input int tx_w);
        return fifo_w / tx_w;
    endfunction

    // Host transaction length in RIFFA words.
    function automatic int calc_txn_len(input int entries, input int fifo_w);
        return (entries * fifo_w) / RIFFA_WORD_W;
    endfunction

endpackage

// File: rtl/rdback_serializer.sv
// Holds one readback FIFO entry and emits it as TX_WIDTH beats, LSB slice first,
// under a valid/ren handshake. The beat mux output is registered.
module rdback_serializer
    import rdback_sender_pkg::*;
#(
    parameter int FIFO_WIDTH = 512,
    parameter int TX_WIDTH   = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [FIFO_WIDTH-1:0] load_data,
    output logic [TX_WIDTH-1:0]   tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ren,
    output logic                  last_acc
);

    localparam int BEATS = calc_beats(FIFO_WIDTH, TX_WIDTH);
    localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [FIFO_WIDTH-1:0]           hold_q;
    logic [BEATS-1:0][TX_WIDTH-1:0]  slices;
    logic                            hold_vld;
    logic [BCW-1:0]                  beat_cnt;
    logic                            accept;

    assign slices   = hold_q;
    assign accept   = hold_vld && tx_ren;
    assign last_acc = accept && (beat_cnt == BCW'(BEATS - 1));
    assign tx_valid = hold_vld;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_q   <= '0;
            hold_vld <= 1'b0;
            beat_cnt <= '0;
            tx_data  <= '0;
        end else if (load) begin
            // A load only ever lands on an empty holding register.
            hold_q   <= load_data;
            hold_vld <= 1'b1;
            beat_cnt <= '0;
            tx_data  <= load_data[TX_WIDTH-1:0];
        end else if (accept) begin
            if (last_acc) begin
                hold_vld <= 1'b0;
                beat_cnt <= '0;
            end else begin
                beat_cnt <= beat_cnt + 1'b1;
                tx_data  <= slices[beat_cnt + 1'b1];
            end
        end
    end

endmodule

// File: rtl/rdback_sender.sv
// Drains the readback FIFO into fixed-length RIFFA TX transactions.
// Top holds the request FSM and per-transaction entry counters.
module rdback_sender
    import rdback_sender_pkg::*;
#(
    parameter int FIFO_WIDTH  = 512,
    parameter int TX_WIDTH    = 128,
    parameter int TXN_ENTRIES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rdback_fifo_empty,
    output logic                  rdback_fifo_rden,
    input  logic [FIFO_WIDTH-1:0] rdback_fifo_rddata,
    output logic                  chnl_tx,
    input  logic                  chnl_tx_ack,
    output logic                  chnl_tx_last,
    output logic [31:0]           chnl_tx_len,
    output logic [30:0]           chnl_tx_off,
    output logic [TX_WIDTH-1:0]   chnl_tx_data,
    output logic                  chnl_tx_data_valid,
    input  logic                  chnl_tx_data_ren
);

    localparam int               CNT_W      = $clog2(TXN_ENTRIES + 1);
    localparam logic [CNT_W-1:0] TXN_N      = CNT_W'(TXN_ENTRIES);
    localparam logic [CNT_W-1:0] LAST_ENTRY = CNT_W'(TXN_ENTRIES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] popped_cnt, sent_cnt;
    logic             pop_q;
    logic             last_acc;
    logic             txn_done;

    assign chnl_tx_last = 1'b1;
    assign chnl_tx_off  = '0;
    assign chnl_tx_len  = 32'(calc_txn_len(TXN_ENTRIES, FIFO_WIDTH));
    assign txn_done     = last_acc && (sent_cnt == LAST_ENTRY);

    always_comb begin
        state_d          = state_q;
        chnl_tx          = 1'b0;
        rdback_fifo_rden = 1'b0;
        case (state_q)
            ST_IDLE: if (!rdback_fifo_empty) state_d = ST_REQ;
            ST_REQ: begin
                chnl_tx = 1'b1;
                if (chnl_tx_ack) state_d = ST_STREAM;
            end
            ST_STREAM: begin
                chnl_tx = 1'b1;
                // Pop only into a free (or freeing) holding register, one at a time.
                rdback_fifo_rden = rst_n && !rdback_fifo_empty && (popped_cnt < TXN_N) &&
                                   !pop_q && (!chnl_tx_data_valid || last_acc);
                if (txn_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            popped_cnt <= '0;
            sent_cnt   <= '0;
            pop_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            pop_q   <= rdback_fifo_rden;
            if (txn_done) begin
                popped_cnt <= '0;
                sent_cnt   <= '0;
            end else begin
                if (rdback_fifo_rden) popped_cnt <= popped_cnt + 1'b1;
                if (last_acc)         sent_cnt   <= sent_cnt + 1'b1;
            end
        end
    end

    rdback_serializer #(
        .FIFO_WIDTH (FIFO_WIDTH),
        .TX_WIDTH   (TX_WIDTH)
    ) u_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (pop_q),
        .load_data  (rdback_fifo_rddata),
        .tx_data    (chnl_tx_data),
        .tx_valid   (chnl_tx_data_valid),
        .tx_ren     (chnl_tx_data_ren),
        .last_acc   (last_acc)
    );

endmodule

// File: tb/tb_rdback_sender.sv
// Directed bench for rdback_sender: FIFO model, beat-order scoreboard, literal pins.
module tb_rdback_sender;

    localparam int FW    = 512;
    localparam int TW    = 128;
    localparam int NE    = 8;
    localparam int BEATS = FW / TW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_empty;
    logic          rden;
    logic [FW-1:0] rddata = '0;
    logic          chnl_tx;
    logic          ack = 1'b0;
    logic          tx_last;
    logic [31:0]   tx_len;
    logic [30:0]   tx_off;
    logic [TW-1:0] data;
    logic          valid;
    logic          ren = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    logic [FW-1:0] mem [0:127];
    int pushed_total = 0;
    int popped_total = 0;

    always #5 clk = ~clk;

    assign fifo_empty = (pushed_total == popped_total);

    // Readback FIFO with one-cycle read latency.
    always @(posedge clk) begin
        if (rden && !fifo_empty) begin
            rddata       <= mem[popped_total];
            popped_total <= popped_total + 1;
        end
    end

    rdback_sender #(.FIFO_WIDTH(FW), .TX_WIDTH(TW), .TXN_ENTRIES(NE)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .rdback_fifo_empty  (fifo_empty),
        .rdback_fifo_rden   (rden),
        .rdback_fifo_rddata (rddata),
        .chnl_tx            (chnl_tx),
        .chnl_tx_ack        (ack),
        .chnl_tx_last       (tx_last),
        .chnl_tx_len        (tx_len),
        .chnl_tx_off        (tx_off),
        .chnl_tx_data       (data),
        .chnl_tx_data_valid (valid),
        .chnl_tx_data_ren   (ren)
    );

    function automatic logic [TW-1:0] slice(input int i, input int k);
        int idx;
        idx = i * BEATS + k;
        return {32'hC0DE0000 + 32'(idx), 32'(i), 32'(k), 32'h12345678 ^ 32'(idx)};
    endfunction

    function automatic logic [FW-1:0] make_entry(input int i);
        logic [FW-1:0] e;
        e = '0;
        for (int k = 0; k < BEATS; k++) e[k*TW +: TW] = slice(i, k);
        return e;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_entries(input int n);
        for (int j = 0; j < n; j++) begin
            mem[pushed_total] = make_entry(pushed_total);
            pushed_total++;
        end
    endtask

    // Scoreboard: accepted beats must follow FIFO order, LSB slice first.
    // Entries popped before a reset are dropped, so the stream restarts at the next unpopped entry.
    task automatic monitor();
        int exp_entry = 0;
        int exp_beat  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_entry = popped_total;
                exp_beat  = 0;
            end else begin
                chk("tx_consts", {tx_last, tx_off, tx_len}, {1'b1, 31'd0, 32'd128});
                if (rden) chk("pop_nonempty", fifo_empty, 1'b0);
                if (valid) begin
                    chk("beat_in_range", exp_entry < pushed_total, 1'b1);
                    if (exp_entry < pushed_total)
                        chk("beat_data", data, slice(exp_entry, exp_beat));
                    if (ren) begin
                        if (exp_beat == BEATS - 1) begin
                            exp_beat = 0;
                            exp_entry++;
                        end else begin
                            exp_beat++;
                        end
                    end
                end
            end
        end
    endtask

    task automatic wait_req();
        int w = 0;
        while (!chnl_tx && w < 50) begin
            tick();
            w++;
        end
        chk("req_raised", chnl_tx, 1'b1);
        chk("tx_len", tx_len, 32'd128);
    endtask

    task automatic do_txn(input int ack_dly, input bit toggle, input int late_n, input int late_at,
                          output logic [TW-1:0] first_beat, output logic [TW-1:0] last_beat);
        int base;
        int beats;
        base       = popped_total;
        beats      = 0;
        first_beat = '0;
        last_beat  = '0;
        wait_req();
        for (int i = 0; i < ack_dly; i++) begin
            chk("pre_ack_idle", {rden, valid, chnl_tx}, 3'b001);
            tick();
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        for (int c = 0; c < 500; c++) begin
            if (late_n > 0 && c == late_at) begin
                chk("gap_quiet", {valid, rden}, 2'b00);
                push_entries(late_n);
            end
            ren = toggle ? (c % 2 == 0) : 1'b1;
            if (valid && ren) begin
                if (beats == 0) first_beat = data;
                beats++;
                if (beats == NE * BEATS) begin
                    last_beat = data;
                    break;
                end
            end
            tick();
        end
        chk("all_beats", beats, NE * BEATS);
        chk("tx_held_at_last", chnl_tx, 1'b1);
        tick();
        chk("tx_drop", chnl_tx, 1'b0);
        chk("pops_per_txn", popped_total - base, NE);
        ren = 1'b1;
    endtask

    initial begin
        logic [TW-1:0] fb, lb;
        int base;
        int beats;

        push_entries(8);
        fork
            monitor();
        join_none

        // Reset held two cycles with a non-empty FIFO.
        repeat (2) begin
            tick();
            chk("reset_ctrl", {rden, chnl_tx, valid}, 3'b000);
        end
        chk("reset_data", data, '0);
        chk("reset_no_pop", popped_total, 0);
        rst_n = 1'b1;
        ren   = 1'b1;

        // Single transaction, ren always high.
        do_txn(0, 1'b0, 0, 0, fb, lb);
        chk("txn1_first", fb, 128'hC0DE0000_00000000_00000000_12345678);
        chk("txn1_last",  lb, 128'hC0DE001F_00000007_00000003_12345667);

        // Backpressure: ren alternates.
        push_entries(8);
        do_txn(0, 1'b1, 0, 0, fb, lb);
        chk("bp_first", fb, slice(8, 0));

        // Underflow: 3 entries, remaining 5 arrive 20 cycles into the stream.
        push_entries(3);
        do_txn(0, 1'b0, 5, 20, fb, lb);
        chk("uf_last", lb, slice(23, 3));

        // Ack held off 10 cycles.
        push_entries(8);
        do_txn(10, 1'b0, 0, 0, fb, lb);

        // Reset after beat 5 of a transaction.
        push_entries(8);
        base = popped_total;
        wait_req();
        ack = 1'b1;
        tick();
        ack = 1'b0;
        beats = 0;
        for (int c = 0; c < 200; c++) begin
            if (valid && ren) beats++;
            if (beats == 6) break;
            tick();
        end
        chk("mid_beats", beats, 6);
        tick();
        ren   = 1'b0;
        rst_n = 1'b0;
        tick();
        chk("midrst_ctrl", {rden, chnl_tx, valid}, 3'b000);
        chk("midrst_data", data, '0);
        chk("midrst_pops", popped_total - base, 2);
        tick();
        rst_n = 1'b1;
        ren   = 1'b1;
        push_entries(2);
        do_txn(0, 1'b0, 0, 0, fb, lb);
        chk("post_rst_first", fb, 128'hC0DE0088_00000022_00000000_123456F0);

        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
